// File: rtl/countdown_timer.sv
// Parametrised down-counter timer with one-shot or periodic auto-reload, pause,
// abort and restart. Expiry produces a registered single-cycle done pulse.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset_n,
    input  logic             i_w_start,
    input  logic [WIDTH-1:0] i_w_value,
    input  logic             i_w_periodic,
    input  logic             i_w_pause,
    input  logic             i_w_abort,
    output logic             o_w_busy,
    output logic             o_w_done,
    output logic [WIDTH-1:0] o_w_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             periodic_q, periodic_d;
    logic             done_q, done_d;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path infers a latch.
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;

        if (i_w_abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (i_w_start) begin
            reload_d   = i_w_value;
            periodic_d = i_w_periodic;
            if (i_w_value != '0) begin
                count_d = i_w_value;
                state_d = RUN;
            end else begin
                // A zero load expires immediately and never re-arms, even in periodic mode.
                count_d = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == RUN && !i_w_pause) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                done_d = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge i_w_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!i_w_reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reload_q   <= reload_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
        end
    end

    assign o_w_busy  = (state_q == RUN);
    assign o_w_done  = done_q;
    assign o_w_count = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random
// phase, all compared against an integer-arithmetic reference model.
module tb_countdown_timer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             periodic = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: remaining ticks to expiry, the value to re-arm with, and expected outputs.
    bit m_running;
    bit m_periodic;
    bit m_done;
    int m_left;
    int m_reload;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .i_w_clk      (clk),
        .i_w_reset_n  (reset_n),
        .i_w_start    (start),
        .i_w_value    (value),
        .i_w_periodic (periodic),
        .i_w_pause    (pause),
        .i_w_abort    (abort),
        .o_w_busy     (busy),
        .o_w_done     (done),
        .o_w_count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_edge(input bit rn, input bit st, input int v, input bit per,
                              input bit pa, input bit ab);
        if (!rn) begin
            m_running = 0; m_periodic = 0; m_done = 0; m_left = 0; m_reload = 0;
        end else if (ab) begin
            m_running = 0; m_left = 0; m_done = 0;
        end else if (st) begin
            m_reload   = v;
            m_periodic = per;
            m_left     = v;
            m_running  = (v > 0);
            m_done     = (v == 0);
        end else if (m_running && !pa) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_done && m_periodic) m_left = m_reload;
            if (m_left == 0) m_running = 0;
        end else begin
            m_done = 0;
        end
    endtask

    task automatic step(input bit rn, input bit st, input int v, input bit per,
                        input bit pa, input bit ab);
        reset_n  = rn;
        start    = st;
        value    = v[WIDTH-1:0];
        periodic = per;
        pause    = pa;
        abort    = ab;
        @(posedge clk);
        model_edge(rn, st, v, per, pa, ab);
        #1;
        check("busy", 32'(busy), 32'(m_running));
        check("done", 32'(done), 32'(m_done));
        check("count", 32'(count), 32'(m_left));
    endtask

    task automatic tick();
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic launch(input int v, input bit per);
        step(1, 1, v, per, 0, 0);
    endtask

    initial begin
        // Reset state.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(count), 0);

        // N=5 one-shot: count 5..1, done exactly at E0+5, then idle.
        launch(5, 0);
        check("os5_count0", 32'(count), 5);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("os5_count", 32'(count), 32'(5 - k));
            check("os5_busy", 32'(busy), 1);
            check("os5_nodone", 32'(done), 0);
        end
        tick();
        check("os5_done", 32'(done), 1);
        check("os5_busy_end", 32'(busy), 0);
        check("os5_count_end", 32'(count), 0);
        tick();
        check("os5_done_once", 32'(done), 0);

        // N=3 periodic, abort at E0+7: pulses at +3 and +6 only.
        launch(3, 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("per3_done", 32'(done), (k % 3 == 0) ? 1 : 0);
            check("per3_count", 32'(count), 32'(3 - (k % 3)));
        end
        step(1, 0, 0, 0, 0, 1);
        check("per3_abort_busy", 32'(busy), 0);
        check("per3_abort_count", 32'(count), 0);
        repeat (3) begin
            tick();
            check("per3_no_done", 32'(done), 0);
        end

        // N=4 one-shot, pause 3 cycles at count=2: done at E0+7.
        launch(4, 0);
        tick();
        tick();
        repeat (3) begin
            step(1, 0, 0, 0, 1, 0);
            check("pause_hold", 32'(count), 2);
        end
        tick();
        check("pause_cnt1", 32'(count), 1);
        tick();
        check("pause_done", 32'(done), 1);

        // Pause while count=1 delays done until release.
        launch(2, 0);
        tick();
        repeat (2) begin
            step(1, 0, 0, 0, 1, 0);
            check("pause1_nodone", 32'(done), 0);
        end
        tick();
        check("pause1_done", 32'(done), 1);

        // N=10 restarted at count=6 with N=2: done at Er+2 only.
        launch(10, 0);
        repeat (4) tick();
        check("rs_count6", 32'(count), 6);
        launch(2, 0);
        tick();
        check("rs_nodone", 32'(done), 0);
        tick();
        check("rs_done", 32'(done), 1);

        // Simultaneous abort + start.
        launch(5, 0);
        step(1, 1, 7, 0, 0, 1);
        check("abst_busy", 32'(busy), 0);
        check("abst_count", 32'(count), 0);
        check("abst_done", 32'(done), 0);

        // N=0 periodic: single immediate done, never busy.
        launch(0, 1);
        check("n0_done", 32'(done), 1);
        check("n0_busy", 32'(busy), 0);
        repeat (3) begin
            tick();
            check("n0_quiet", 32'(done), 0);
        end

        // N=255: done at E0+255 without wrap.
        launch(255, 0);
        repeat (254) tick();
        check("n255_cnt1", 32'(count), 1);
        tick();
        check("n255_done", 32'(done), 1);
        check("n255_count", 32'(count), 0);
        tick();

        // N=1 periodic: done every cycle.
        launch(1, 1);
        repeat (5) begin
            tick();
            check("n1p_done", 32'(done), 1);
            check("n1p_busy", 32'(busy), 1);
        end
        step(1, 0, 0, 0, 0, 1);

        // Reset on the expiry edge suppresses done; next run is normal.
        launch(3, 0);
        tick();
        tick();
        step(0, 0, 0, 0, 0, 0);
        check("rstexp_done", 32'(done), 0);
        check("rstexp_busy", 32'(busy), 0);
        check("rstexp_count", 32'(count), 0);
        launch(2, 0);
        tick();
        tick();
        check("rstexp_next_done", 32'(done), 1);

        // Random phase against the model.
        for (int i = 0; i < 2000; i++) begin
            bit rn, st, per, pa, ab;
            int v;
            rn  = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 9) == 0);
            ab  = ($urandom_range(0, 29) == 0);
            pa  = ($urandom_range(0, 3) == 0);
            per = $urandom_range(0, 1);
            v   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            step(rn, st, v, per, pa, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Parametrised down-counter timer for the debouncer datapath. It generalises the fixed 8-bit load/count/done FSM with a configurable width, one-shot or periodic mode, pause, abort and restart. It is used as the stability/sample-interval timer feeding debouncer channels. `o_w_done` is a registered single-cycle pulse on expiry; `o_w_busy` and `o_w_count` expose progress.

## Interface
- `WIDTH`, default 8: counter and load-value width; legal range 2..32.
- `i_w_clk`  in  1  clock; all logic is on the rising edge.
- `i_w_reset_n`  in  1  reset, synchronous, active-low.
- `i_w_start`  in  1  load request: latch `i_w_value` and `i_w_periodic`, then (re)start counting.
- `i_w_value`  in  WIDTH  load value N, sampled only when `i_w_start`=1.
- `i_w_periodic`  in  1  mode, sampled with `i_w_start`: 0 = one-shot, 1 = periodic auto-reload.
- `i_w_pause`  in  1  level; freezes the count while high.
- `i_w_abort`  in  1  cancels the run; no done pulse.
- `o_w_busy`  out  1  high while state is RUN.
- `o_w_done`  out  1  one-cycle registered expiry pulse.
- `o_w_count`  out  WIDTH  current counter value.

## Operation
- Registers: state (IDLE, RUN), counter[WIDTH], reload[WIDTH], periodic flag, done flop.
- Reset (`i_w_reset_n`=0 at an edge) sets state=IDLE and clears counter, reload, periodic flag and done. After reset: `o_w_busy`=0, `o_w_done`=0, `o_w_count`=0.
- Per-edge priority: reset > abort > start > pause > decrement.
- Abort (any state): state=IDLE, counter=0, done=0. Abort wins over a simultaneous start or expiry.
- Start (any state, no abort):
  - reload=N; periodic flag=`i_w_periodic`.
  - N≥1: counter=N, state=RUN.
  - N=0: counter=0, done=1, state=IDLE. This is always a one-shot, even with periodic=1.
  - A start during RUN restarts the timer. The interrupted run produces no done pulse.
- RUN, no start, no abort:
  - Pause=1: counter and state hold; done=0.
  - Counter>1: counter decrements by 1.
  - Counter==1: done=1.
    - Periodic: counter=reload, state stays RUN.
    - One-shot: counter=0, state=IDLE.
- IDLE, no start: counter holds; pause has no effect.
- Done is 0 on every edge that does not set it, so it is never high for 2 consecutive cycles unless N=1 in periodic mode, where it pulses every cycle.
- Arithmetic is unsigned. The decrement never wraps: counter==0 is never decremented. Maximum N = 2^WIDTH−1.

## Timing
- Start is sampled at edge E0 with N≥1.
  - After E0: `o_w_count`=N, `o_w_busy`=1.
  - After E0+k: count = N−k, for k<N, with no pause.
  - Expiry at edge E0+N: `o_w_done`=1 for exactly the cycle E0+N..E0+N+1.
  - One-shot: after E0+N, busy=0 and count=0.
- Latency from start to done is N unpaused cycles. Each paused RUN cycle adds exactly 1.
- Periodic: done at E0+N, E0+2N, … Count reads N right after each pulse edge. Busy stays 1.
- N=0: done after E0 (latency 0); busy stays 0.
- Restart at edge Er replaces the run: the new expiry is at Er+N_new.
- Reset mid-run: outputs reach reset values after the reset edge. A done pending on that same edge is suppressed.

## Test plan
- Reset, then start with N=5 one-shot → count 5,4,3,2,1,0; done high exactly at edge E0+5; busy high for edges E0..E0+4 only.
- N=3 periodic → done at E0+3, +6, +9; count cycles 3,2,1,3,…; abort at E0+7 → busy=0, count=0, no done at E0+9.
- N=4 one-shot, pause held 3 cycles starting when count=2 → count holds at 2; done at E0+7. A pause held while count=1 delays done until the pause releases.
- N=10 restarted at count=6 with N=2 → no done for the first run; done at Er+2. Simultaneous abort+start → IDLE, count=0, no done.
- Boundaries:
  - N=0 with periodic=1 → single done after E0, busy never asserts.
  - WIDTH=8, N=255 → done at E0+255, no wrap.
  - N=1 periodic → done high every cycle.
- `i_w_reset_n`=0 at the edge the counter would expire → done stays 0; busy=0, count=0; the next start behaves normally.
